// File: rtl/bidir_dp_syncram_pkg.sv
// -----------------------------------------------------------------------------
// bidir_dp_syncram_pkg
// Shared constants and helpers for the dual-port synchronous RAM model.
//   DEF_ADDR_W / DEF_DATA_W / DEF_BYTE_W : default geometry (16384 x 32, bytes)
//   MAX_DATA_W                           : widest word the merge helper handles
//   be_w()       : number of byte lanes in a word
//   byte_merge() : replace the enabled byte lanes of an old word with new data
// -----------------------------------------------------------------------------
package bidir_dp_syncram_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int MAX_DATA_W = 256;

  function automatic int be_w(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Operands are zero-extended to MAX_DATA_W by the caller; lane i/byte_w
  // decides whether bit i comes from the new or the old word.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_DATA_W-1:0] be,
    input int                    byte_w = DEF_BYTE_W
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (be[i / byte_w]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/bidir_dp_syncram_port_rd.sv
// -----------------------------------------------------------------------------
// syncram_port_rd
// Read-data path of one RAM port: same-port read-during-write merge, read
// register with rden hold and synchronous clear, and the optional second
// output register (enabled by defining SYNCRAM_OUTREG_EN).
//   clk_i   : clock
//   rst_i   : synchronous active-high clear of the read register(s)
//   rden_i  : read enable, gates the first register only
//   wren_i  : this port writes an in-range address this cycle
//   be_i    : this port's byte-lane enables
//   wdata_i : this port's write data
//   old_i   : array word at this port's address before the edge (0 if out of range)
//   q_o     : read data
// -----------------------------------------------------------------------------
module syncram_port_rd
  import bidir_dp_syncram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rden_i,
  input  logic                     wren_i,
  input  logic [DATA_W/BYTE_W-1:0] be_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W-1:0]        old_i,
  output logic [DATA_W-1:0]        q_o
);

  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q = '0;

  // A port reading the word it is writing sees its own new lanes.
  always_comb begin
    rd_d = old_i;
    if (wren_i) begin
      rd_d = DATA_W'(byte_merge(MAX_DATA_W'(old_i), MAX_DATA_W'(wdata_i),
                                MAX_DATA_W'(be_i), BYTE_W));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       rd_q <= '0;
    else if (rden_i) rd_q <= rd_d;
  end

`ifdef SYNCRAM_OUTREG_EN
  logic [DATA_W-1:0] out_q = '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) out_q <= '0;
    else       out_q <= rd_q;
  end

  assign q_o = out_q;
`else
  assign q_o = rd_q;
`endif

endmodule

// File: rtl/bidir_dp_syncram.sv
// -----------------------------------------------------------------------------
// bidir_dp_syncram
// True dual-port synchronous RAM with per-byte write enables, single clock.
// Behavioural model of the block RAM behind the instruction/data memory.
// Optional macro SYNCRAM_OUTREG_EN adds an output register (2-cycle reads).
//   clk_i                 : clock
//   rst_i                 : sync active-high, clears read data only
//   addr_x_i / data_x_i   : word address / write data, x = a, b
//   wren_x_i / rden_x_i   : write / read enable
//   byteena_x_i           : byte-lane write enables
//   q_x_o                 : registered read data
// Out-of-range addresses (>= NUM_WORDS) ignore writes and read as 0.
// Same-address double write: port B owns overlapping lanes, others merge.
// -----------------------------------------------------------------------------
module bidir_dp_syncram
  import bidir_dp_syncram_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    BYTE_W    = DEF_BYTE_W,
  parameter int    ADDR_W    = DEF_ADDR_W,
  parameter int    NUM_WORDS = 16384,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        addr_a_i,
  input  logic [DATA_W-1:0]        data_a_i,
  input  logic                     wren_a_i,
  input  logic [DATA_W/BYTE_W-1:0] byteena_a_i,
  input  logic                     rden_a_i,
  output logic [DATA_W-1:0]        q_a_o,
  input  logic [ADDR_W-1:0]        addr_b_i,
  input  logic [DATA_W-1:0]        data_b_i,
  input  logic                     wren_b_i,
  input  logic [DATA_W/BYTE_W-1:0] byteena_b_i,
  input  logic                     rden_b_i,
  output logic [DATA_W-1:0]        q_b_o
);

  localparam int BE_W  = be_w(DATA_W, BYTE_W);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  // Array preload: zeros.
  initial begin
    for (int i = 0; i < NUM_WORDS; i++) mem_q[i] = '0;
  end

  logic              a_ok, b_ok, wr_a, wr_b, collide;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [DATA_W-1:0] old_a, old_b, wdat_a_d, base_b, wdat_b_d;
  logic [BE_W-1:0]   be_a, be_b;

  assign be_a  = byteena_a_i;
  assign be_b  = byteena_b_i;
  assign a_ok  = 32'(addr_a_i) < NUM_WORDS;
  assign b_ok  = 32'(addr_b_i) < NUM_WORDS;
  assign idx_a = IDX_W'(addr_a_i);
  assign idx_b = IDX_W'(addr_b_i);
  assign old_a = a_ok ? mem_q[idx_a] : '0;
  assign old_b = b_ok ? mem_q[idx_b] : '0;
  assign wr_a  = wren_a_i & a_ok;
  assign wr_b  = wren_b_i & b_ok;
  assign collide = wr_a & wr_b & (addr_a_i == addr_b_i);

  // On a collision port B's merge starts from port A's merged word, so A's
  // lanes survive wherever B does not enable, and only B's word is stored.
  always_comb begin
    wdat_a_d = DATA_W'(byte_merge(MAX_DATA_W'(old_a), MAX_DATA_W'(data_a_i),
                                  MAX_DATA_W'(be_a), BYTE_W));
    base_b   = collide ? wdat_a_d : old_b;
    wdat_b_d = DATA_W'(byte_merge(MAX_DATA_W'(base_b), MAX_DATA_W'(data_b_i),
                                  MAX_DATA_W'(be_b), BYTE_W));
  end

  always_ff @(posedge clk_i) begin
    if (wr_a && !collide) mem_q[idx_a] <= wdat_a_d;
    if (wr_b)             mem_q[idx_b] <= wdat_b_d;
  end

  // Read paths take the pre-edge array word, which gives old data to the
  // other port on a mixed-port read-during-write.
  syncram_port_rd #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_port_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rden_i  (rden_a_i),
    .wren_i  (wr_a),
    .be_i    (be_a),
    .wdata_i (data_a_i),
    .old_i   (old_a),
    .q_o     (q_a_o)
  );

  syncram_port_rd #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_port_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rden_i  (rden_b_i),
    .wren_i  (wr_b),
    .be_i    (be_b),
    .wdata_i (data_b_i),
    .old_i   (old_b),
    .q_o     (q_b_o)
  );

endmodule

// File: tb/tb_bidir_dp_syncram.sv
// -----------------------------------------------------------------------------
// tb_bidir_dp_syncram
// Directed bench for bidir_dp_syncram with NUM_WORDS reduced to 1000 so that
// out-of-range addresses are reachable. Read latency follows SYNCRAM_OUTREG_EN.
// -----------------------------------------------------------------------------
module tb_bidir_dp_syncram;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int BE_W      = 4;
  localparam int NUM_WORDS = 1000;
`ifdef SYNCRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              wren_a, wren_b, rden_a, rden_b;
  logic [BE_W-1:0]   be_a, be_b;
  logic [DATA_W-1:0] q_a, q_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bidir_dp_syncram #(
    .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
    .NUM_WORDS(NUM_WORDS), .INIT_FILE("")
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .addr_a_i(addr_a), .data_a_i(data_a), .wren_a_i(wren_a),
    .byteena_a_i(be_a), .rden_a_i(rden_a), .q_a_o(q_a),
    .addr_b_i(addr_b), .data_b_i(data_b), .wren_b_i(wren_b),
    .byteena_b_i(be_b), .rden_b_i(rden_b), .q_b_o(q_b)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    be_a = '0; be_b = '0;
  endtask

  // Remaining pipeline cycles with rden low so the first stage holds.
  task automatic settle();
    idle();
    repeat (LAT - 1) step();
  endtask

  task automatic wr(input bit port_b, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    if (port_b) begin addr_b = a; data_b = d; be_b = be; wren_b = 1'b1; end
    else        begin addr_a = a; data_a = d; be_a = be; wren_a = 1'b1; end
    step();
    idle();
  endtask

  task automatic rd(input bit port_b, input logic [ADDR_W-1:0] a);
    if (port_b) begin addr_b = a; rden_b = 1'b1; end
    else        begin addr_a = a; rden_a = 1'b1; end
    step();
    settle();
  endtask

  initial begin
    rst = 1'b0; addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    idle();
    #1;
    chk("pre_reset_qa", q_a, 32'h0);
    chk("pre_reset_qb", q_b, 32'h0);

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_qa", q_a, 32'h0);
    chk("reset_qb", q_b, 32'h0);

    // Full write then read on port A
    wr(0, 14'h0010, 32'hDEADBEEF, 4'b1111);
    rd(0, 14'h0010);
    chk("wr_rd_a", q_a, 32'hDEADBEEF);

    // Partial write on port B
    wr(1, 14'h0010, 32'h11223344, 4'b0101);
    rd(1, 14'h0010);
    chk("partial_b", q_b, 32'hDE22BE44);

    // Mixed-port read-during-write returns old data
    wr(0, 14'd5, 32'hAAAAAAAA, 4'b1111);
    addr_a = 14'd5; data_a = 32'h55555555; be_a = 4'b1111; wren_a = 1'b1;
    addr_b = 14'd5; rden_b = 1'b1;
    step();
    settle();
    chk("mixed_rdw_old", q_b, 32'hAAAAAAAA);
    rd(1, 14'd5);
    chk("mixed_rdw_new", q_b, 32'h55555555);

    // rden low holds the previous read data
    addr_b = 14'h0010;
    step();
    chk("rden_hold", q_b, 32'h55555555);

    // Same-port read-during-write merges new and old lanes
    wr(0, 14'd7, 32'h12345678, 4'b1111);
    addr_a = 14'd7; data_a = 32'hFFFFFFFF; be_a = 4'b0011;
    wren_a = 1'b1; rden_a = 1'b1;
    step();
    settle();
    chk("same_rdw", q_a, 32'h1234FFFF);
    rd(0, 14'd7);
    chk("same_rdw_mem", q_a, 32'h1234FFFF);

    // Both ports write one address: B wins, non-overlapping lanes merge
    addr_a = 14'd9; data_a = 32'h00000001; be_a = 4'b1111; wren_a = 1'b1;
    addr_b = 14'd9; data_b = 32'h00000002; be_b = 4'b1111; wren_b = 1'b1;
    step();
    idle();
    rd(0, 14'd9);
    chk("dual_wr_full", q_a, 32'h00000002);
    addr_a = 14'd9; data_a = 32'hAAAAAAAA; be_a = 4'b1100; wren_a = 1'b1;
    addr_b = 14'd9; data_b = 32'hBBBBBBBB; be_b = 4'b0110; wren_b = 1'b1;
    step();
    idle();
    rd(1, 14'd9);
    chk("dual_wr_merge", q_b, 32'hAABBBB02);

    // Out-of-range: read gives 0, write ignored, no wrap onto word 0
    rd(0, 14'h0010);
    chk("pre_oob_a", q_a, 32'hDE22BE44);
    rd(0, 14'd1000);
    chk("oob_read", q_a, 32'h0);
    wr(1, 14'd1000, 32'hCAFEBABE, 4'b1111);
    rd(1, 14'd1000);
    chk("oob_write_ign", q_b, 32'h0);
    rd(1, 14'd0);
    chk("oob_no_wrap", q_b, 32'h0);

    // Reset mid-stream: reads discarded, writes still happen, contents kept
    rd(0, 14'h0010);
    rd(1, 14'd7);
    chk("pre_rst_qa", q_a, 32'hDE22BE44);
    chk("pre_rst_qb", q_b, 32'h1234FFFF);
    rst = 1'b1;
    addr_a = 14'h0020; data_a = 32'hCAFEF00D; be_a = 4'b1111;
    wren_a = 1'b1; rden_a = 1'b1;
    addr_b = 14'h0010; rden_b = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("rst_clear_qa", q_a, 32'h0);
    chk("rst_clear_qb", q_b, 32'h0);
    rd(0, 14'h0010);
    chk("post_rst_rd", q_a, 32'hDE22BE44);
    rd(1, 14'h0020);
    chk("wr_during_rst", q_b, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
